stopwatch_controller: RTL

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/bcd_digit_counter.sv | 23 ++
 rtl/stopwatch_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// STOPWATCH_LAP_EN adds the LAP state to the state enum.
package stopwatch_pkg;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  typedef logic [3:0] bcd_t;

  // Full displayed time, most significant digit first
  typedef struct packed {
    bcd_t min;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t hund_tens;
    bcd_t hund_ones;
  } time_t;

  localparam int unsigned DIGIT_MAX    = 9;
  localparam int unsigned SEC_TENS_MAX = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: counts 0..MAX on enable, carry_c flags the wrap back to 0.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output bcd_t value,
  output logic carry_c
);

  assign carry_c = en && (value == 4'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr)   value <= '0;
    else if (carry_c) value <= '0;
    else if (en)      value <= value + 4'd1;
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch: edge-detected buttons and ms tick, BCD time chain, registered display.
// Define STOPWATCH_LAP_EN to build the LAP state, lap register and Lap_active.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_HUNDREDTH = 10,
  parameter int unsigned MAX_MIN             = 9
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Pulse_ms,
  input  logic Start_Stop,
  input  logic Lap,
  input  logic Clear,
  output bcd_t Min,
  output bcd_t Sec_tens,
  output bcd_t Sec_ones,
  output bcd_t Hund_tens,
  output bcd_t Hund_ones,
  output logic Running,
  output logic Lap_active
);

  localparam int unsigned PW = (TICKS_PER_HUNDREDTH > 1) ? $clog2(TICKS_PER_HUNDREDTH) : 1;

  state_t         state;
  logic [3:0]     in_q, in_qq, rise_c;
  logic           tick_c, ss_c, lap_c, clr_c;
  logic           count_c, hund_en_c;
  logic [PW-1:0]  prescaler;
  bcd_t           ho, ht, so, st, mn;
  logic           c_ho, c_ht, c_so, c_st, min_carry_unused;
  time_t          live_c;

  // Input pipeline: bit 0 ms pulse, 1 Start_Stop, 2 Lap, 3 Clear
  always_ff @(posedge Clock) begin
    if (Reset) begin
      in_q  <= '0;
      in_qq <= '0;
    end else begin
      in_q  <= {Clear, Lap, Start_Stop, Pulse_ms};
      in_qq <= in_q;
    end
  end

  assign rise_c = in_q & ~in_qq;
  assign tick_c = rise_c[0];
  assign ss_c   = rise_c[1];
  assign lap_c  = rise_c[2];
  assign clr_c  = rise_c[3];

  // A tick sharing its cycle with a Start_Stop edge is dropped either way
  assign count_c   = tick_c && Running && !ss_c && !clr_c;
  assign hund_en_c = count_c && (prescaler == PW'(TICKS_PER_HUNDREDTH - 1));

  always_ff @(posedge Clock) begin
    if (Reset || clr_c) prescaler <= '0;
    else if (count_c)   prescaler <= hund_en_c ? '0 : prescaler + 1'b1;
  end

  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_hund_ones (
    .clk(Clock), .rst(Reset), .clr(clr_c), .en(hund_en_c), .value(ho), .carry_c(c_ho));
  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_hund_tens (
    .clk(Clock), .rst(Reset), .clr(clr_c), .en(c_ho), .value(ht), .carry_c(c_ht));
  bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(Clock), .rst(Reset), .clr(clr_c), .en(c_ht), .value(so), .carry_c(c_so));
  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(Clock), .rst(Reset), .clr(clr_c), .en(c_so), .value(st), .carry_c(c_st));
  bcd_digit_counter #(.MAX(MAX_MIN)) u_min (
    .clk(Clock), .rst(Reset), .clr(clr_c), .en(c_st), .value(mn), .carry_c(min_carry_unused));

  assign live_c = {mn, st, so, ht, ho};

  // Mode FSM; priority Clear > Start_Stop > Lap
  always_ff @(posedge Clock) begin
    if (Reset || clr_c) begin
      state   <= IDLE;
      Running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      Lap_active <= 1'b0;
`endif
    end else if (ss_c) begin
      case (state)
        IDLE, PAUSE: begin
          state   <= RUN;
          Running <= 1'b1;
        end
        default: begin
          state   <= PAUSE;
          Running <= 1'b0;
        end
      endcase
`ifdef STOPWATCH_LAP_EN
      Lap_active <= 1'b0;
    end else if (lap_c) begin
      if (state == RUN) begin
        state      <= LAP;
        Lap_active <= 1'b1;
      end else if (state == LAP) begin
        state      <= RUN;
        Lap_active <= 1'b0;
      end
`endif
    end
  end

`ifdef STOPWATCH_LAP_EN
  time_t lap_q;
  logic  lap_enter_c;

  assign lap_enter_c = lap_c && !ss_c && !clr_c && (state == RUN);

  always_ff @(posedge Clock) begin
    if (Reset || clr_c)   lap_q <= '0;
    else if (lap_enter_c) lap_q <= live_c;
  end
`else
  logic lap_edge_unused;
  assign lap_edge_unused = lap_c;
  assign Lap_active      = 1'b0;
`endif

  // Display register trails the live counters by one cycle
  always_ff @(posedge Clock) begin
    if (Reset) {Min, Sec_tens, Sec_ones, Hund_tens, Hund_ones} <= '0;
`ifdef STOPWATCH_LAP_EN
    else if (state == LAP) {Min, Sec_tens, Sec_ones, Hund_tens, Hund_ones} <= lap_q;
`endif
    else {Min, Sec_tens, Sec_ones, Hund_tens, Hund_ones} <= live_c;
  end

endmodule
